// File: rtl/line_cache_ctr.sv
// line_cache_ctr: cache controller FSM with multi-word refill, wait-state counter and optional copy-back
//
// Optional feature macro: CACHE_WRITEBACK_EN (copy-back, write-allocate, dirty eviction).
// Without it, writes are write-through with no allocate, and dirty is ignored.
//
// Ports:
//   clock, reset         clock and synchronous active-high reset
//   PStrobe, PRw         processor request and direction (1 = read)
//   PReady               one-cycle request-complete pulse
//   tag_match, valid,    tag/valid/dirty status of the addressed line
//   dirty
//   SysStrobe, SysRW     system transfer start and direction (1 = read)
//   word_index           word within line during refill/evict
//   evict                system address uses the stored tag
//   write                cache data array write enable
//   select_CacheData     cache write data source (1 = system)
//   select_PData         processor read data source (1 = system)
//   open_SysData         drive system data bus
//   open_PData           drive processor data bus
//   clear_valid          clear addressed line valid bit
//   tag_write            write tag, set valid, clear dirty
//   set_dirty            set addressed line dirty bit
module line_cache_ctr #(
   parameter int LINE_WORDS  = 4,
   parameter int WAIT_CYCLES = 3,
   parameter int IDX_W       = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             PStrobe,
   input  logic             PRw,
   output logic             PReady,
   input  logic             tag_match,
   input  logic             valid,
   input  logic             dirty,
   output logic             SysStrobe,
   output logic             SysRW,
   output logic [IDX_W-1:0] word_index,
   output logic             evict,
   output logic             write,
   output logic             select_CacheData,
   output logic             select_PData,
   output logic             open_SysData,
   output logic             open_PData,
   output logic             clear_valid,
   output logic             tag_write,
   output logic             set_dirty
);
`ifdef CACHE_WRITEBACK_EN
   localparam logic WB = 1'b1;
`else
   localparam logic WB = 1'b0;
`endif
   localparam logic [IDX_W-1:0] LAST  = IDX_W'(LINE_WORDS - 1);
   localparam logic [3:0]       WAITS = 4'(WAIT_CYCLES);
   typedef enum logic [3:0] {
      IDLE, LOOKUP, EVICT_REQ, EVICT_WAIT, EVICT_WORD, REFILL_REQ,
      REFILL_WAIT, REFILL_WORD, MERGE, WRITE_REQ, WRITE_WAIT, DONE
   } state_t;
   state_t           state_q;
   logic [3:0]       cnt_q;
   logic [IDX_W-1:0] idx_q;
   logic             hit_q;
   logic             hit, last, need_evict, miss_next_evict;
   assign hit        = tag_match && valid;
   assign last       = idx_q == LAST;
   // dirty only matters in copy-back builds; WB gates it away otherwise
   assign need_evict = WB && valid && dirty;
   assign miss_next_evict = need_evict;
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         hit_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE:        if (PStrobe) state_q <= LOOKUP;
            LOOKUP: begin
               hit_q <= hit;
               if (PRw)     state_q <= hit ? IDLE  : (miss_next_evict ? EVICT_REQ : REFILL_REQ);
               else if (WB) state_q <= hit ? MERGE : (miss_next_evict ? EVICT_REQ : REFILL_REQ);
               else         state_q <= WRITE_REQ;
            end
            EVICT_REQ: begin
               cnt_q   <= WAITS;
               state_q <= EVICT_WAIT;
            end
            EVICT_WAIT: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) state_q <= EVICT_WORD;
            end
            EVICT_WORD: begin
               idx_q   <= last ? '0 : idx_q + IDX_W'(1);
               state_q <= last ? REFILL_REQ : EVICT_REQ;
            end
            REFILL_REQ: begin
               cnt_q   <= WAITS;
               state_q <= REFILL_WAIT;
            end
            REFILL_WAIT: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) state_q <= REFILL_WORD;
            end
            REFILL_WORD: begin
               idx_q   <= last ? '0 : idx_q + IDX_W'(1);
               state_q <= last ? (PRw ? DONE : MERGE) : REFILL_REQ;
            end
            MERGE:       state_q <= DONE;
            WRITE_REQ: begin
               cnt_q   <= WAITS;
               state_q <= WRITE_WAIT;
            end
            WRITE_WAIT: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) state_q <= DONE;
            end
            DONE:        state_q <= IDLE;
            default:     state_q <= IDLE;
         endcase
      end
   end
   logic in_evict, read_hit;
   assign in_evict = WB && (state_q == EVICT_REQ || state_q == EVICT_WAIT || state_q == EVICT_WORD);
   assign read_hit = state_q == LOOKUP && PRw && hit;
   assign PReady           = read_hit || state_q == DONE;
   assign open_PData       = read_hit || (state_q == DONE && PRw);
   assign select_PData     = 1'b0;
   assign SysStrobe        = state_q == REFILL_REQ || state_q == WRITE_REQ || (in_evict && state_q == EVICT_REQ);
   assign SysRW            = state_q == REFILL_REQ;
   // index returns to 0 after the last word, so it reads 0 outside transfers
   assign word_index       = idx_q;
   assign evict            = in_evict;
   // the write-through hit updates the cache in the same cycle the bus write starts
   assign write            = state_q == REFILL_WORD || (WB && state_q == MERGE) || (state_q == WRITE_REQ && hit_q);
   assign select_CacheData = state_q == REFILL_WORD;
   assign open_SysData     = state_q == WRITE_REQ || in_evict;
   // invalidate before the first refill word so an aborted refill leaves the line invalid
   assign clear_valid      = state_q == REFILL_REQ && idx_q == '0;
   assign tag_write        = state_q == REFILL_WORD && last;
   assign set_dirty        = WB && state_q == MERGE;
endmodule

// File: tb/tb_line_cache_ctr.sv
// tb_line_cache_ctr: directed self-checking bench for line_cache_ctr
module tb_line_cache_ctr;
   logic clock = 1'b0;
   logic reset, PStrobe, PRw, tag_match, valid, dirty;
   logic PReady, SysStrobe, SysRW, evict, write, select_CacheData, select_PData;
   logic open_SysData, open_PData, clear_valid, tag_write, set_dirty;
   logic [1:0] word_index;
   logic u1_PReady, u1_SysStrobe, u1_SysRW, u1_evict, u1_write, u1_scd, u1_spd;
   logic u1_osd, u1_opd, u1_clr, u1_tagw, u1_setd;
   logic [0:0] u1_idx;
   int checks = 0;
   int errors = 0;
   logic [63:0] m_ready, m_strobe, m_rw, m_write, m_scd, m_osys, m_op, m_clr, m_tagw, m_dirty, m_evict, m_any, u1_ready;
   logic [1:0]  idx_a [64];
   logic        u1_idx_or;
   always #5 clock = ~clock;
   line_cache_ctr u0 (
      .clock(clock), .reset(reset), .PStrobe(PStrobe), .PRw(PRw), .PReady(PReady),
      .tag_match(tag_match), .valid(valid), .dirty(dirty), .SysStrobe(SysStrobe), .SysRW(SysRW),
      .word_index(word_index), .evict(evict), .write(write), .select_CacheData(select_CacheData),
      .select_PData(select_PData), .open_SysData(open_SysData), .open_PData(open_PData),
      .clear_valid(clear_valid), .tag_write(tag_write), .set_dirty(set_dirty)
   );
   line_cache_ctr #(.LINE_WORDS(1), .WAIT_CYCLES(1)) u1 (
      .clock(clock), .reset(reset), .PStrobe(PStrobe), .PRw(PRw), .PReady(u1_PReady),
      .tag_match(tag_match), .valid(valid), .dirty(dirty), .SysStrobe(u1_SysStrobe), .SysRW(u1_SysRW),
      .word_index(u1_idx), .evict(u1_evict), .write(u1_write), .select_CacheData(u1_scd),
      .select_PData(u1_spd), .open_SysData(u1_osd), .open_PData(u1_opd),
      .clear_valid(u1_clr), .tag_write(u1_tagw), .set_dirty(u1_setd)
   );
   logic [13:0] outs0;
   assign outs0 = {PReady, SysStrobe, SysRW, evict, write, select_CacheData, select_PData,
                   open_SysData, open_PData, clear_valid, tag_write, set_dirty, word_index};
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic do_reset;
      reset   = 1'b1;
      PStrobe = 1'b0;
      @(posedge clock);
      #1 reset = 1'b0;
   endtask
   task automatic run(input logic rw, input logic tm, input logic v, input logic d, input int n, input int rst_at);
      PRw = rw; tag_match = tm; valid = v; dirty = d;
      {m_ready, m_strobe, m_rw, m_write, m_scd, m_osys, m_op} = '0;
      {m_clr, m_tagw, m_dirty, m_evict, m_any, u1_ready} = '0;
      u1_idx_or = 1'b0;
      for (int i = 0; i < n; i++) begin
         PStrobe = (i == 0);
         reset   = (i == rst_at);
         @(negedge clock);
         m_ready[i] = PReady;      m_strobe[i] = SysStrobe;   m_rw[i]   = SysRW;
         m_write[i] = write;       m_scd[i] = select_CacheData; m_osys[i] = open_SysData;
         m_op[i]    = open_PData;  m_clr[i] = clear_valid;    m_tagw[i] = tag_write;
         m_dirty[i] = set_dirty;   m_evict[i] = evict;        m_any[i]  = |outs0;
         idx_a[i]   = word_index;  u1_ready[i] = u1_PReady;   u1_idx_or = u1_idx_or | u1_idx[0];
         @(posedge clock);
         #1;
      end
      PStrobe = 1'b0;
      reset   = 1'b0;
   endtask
   initial begin
      PRw = 1'b1; tag_match = 1'b0; valid = 1'b0; dirty = 1'b0;
      do_reset();
      @(negedge clock);
      check("reset_outputs", 64'(outs0), 64'h0);
      @(posedge clock);
      #1;
      // read hit
      do_reset();
      run(1'b1, 1'b1, 1'b1, 1'b0, 4, -1);
      check("hit_ready", m_ready, 64'h2);
      check("hit_open_pdata", m_op, 64'h2);
      check("hit_no_sysstrobe", m_strobe, 64'h0);
      check("hit_no_write", m_write, 64'h0);
      // read miss, 4 words x (1 + 3 + 1) cycles
      do_reset();
      run(1'b1, 1'b0, 1'b1, 1'b0, 25, -1);
      check("miss_sysstrobe", m_strobe, (64'h1 << 2) | (64'h1 << 7) | (64'h1 << 12) | (64'h1 << 17));
      check("miss_sysrw", m_rw, (64'h1 << 2) | (64'h1 << 7) | (64'h1 << 12) | (64'h1 << 17));
      check("miss_write", m_write, (64'h1 << 6) | (64'h1 << 11) | (64'h1 << 16) | (64'h1 << 21));
      check("miss_sel_cachedata", m_scd, (64'h1 << 6) | (64'h1 << 11) | (64'h1 << 16) | (64'h1 << 21));
      for (int w = 0; w < 4; w++) check($sformatf("miss_word_index_%0d", w), 64'(idx_a[6 + 5 * w]), 64'(w));
      check("miss_tag_write", m_tagw, 64'h1 << 21);
      check("miss_clear_valid", m_clr, 64'h1 << 2);
      check("miss_ready", m_ready, 64'h1 << 22);
      check("miss_open_pdata", m_op, 64'h1 << 22);
      check("lw1_miss_ready", u1_ready, 64'h1 << 5);
      check("lw1_word_index", 64'(u1_idx_or), 64'h0);
`ifndef CACHE_WRITEBACK_EN
      // write-through hit
      do_reset();
      run(1'b0, 1'b1, 1'b1, 1'b0, 8, -1);
      check("wt_hit_write", m_write, 64'h1 << 2);
      check("wt_hit_sysstrobe", m_strobe, 64'h1 << 2);
      check("wt_hit_open_sysdata", m_osys, 64'h1 << 2);
      check("wt_hit_sysrw", m_rw, 64'h0);
      check("wt_hit_ready", m_ready, 64'h1 << 6);
      check("wt_hit_open_pdata", m_op, 64'h0);
      // write-through miss: no allocate
      do_reset();
      run(1'b0, 1'b0, 1'b0, 1'b0, 8, -1);
      check("wt_miss_write", m_write, 64'h0);
      check("wt_miss_sysstrobe", m_strobe, 64'h1 << 2);
      check("wt_miss_ready", m_ready, 64'h1 << 6);
      // dirty ignored without copy-back
      do_reset();
      run(1'b1, 1'b0, 1'b1, 1'b1, 25, -1);
      check("nowb_dirty_ready", m_ready, 64'h1 << 22);
      check("nowb_dirty_evict", m_evict, 64'h0);
`else
      // copy-back write hit
      do_reset();
      run(1'b0, 1'b1, 1'b1, 1'b0, 6, -1);
      check("wb_hit_ready", m_ready, 64'h1 << 3);
      check("wb_hit_sysstrobe", m_strobe, 64'h0);
      check("wb_hit_set_dirty", m_dirty, 64'h1 << 2);
      // copy-back write miss on dirty line
      do_reset();
      run(1'b0, 1'b0, 1'b1, 1'b1, 46, -1);
      check("wb_evict_strobes", m_evict & m_strobe, (64'h1 << 2) | (64'h1 << 7) | (64'h1 << 12) | (64'h1 << 17));
      check("wb_refill_strobes", m_rw, (64'h1 << 22) | (64'h1 << 27) | (64'h1 << 32) | (64'h1 << 37));
      check("wb_set_dirty", m_dirty, 64'h1 << 42);
      check("wb_ready", m_ready, 64'h1 << 43);
`endif
      // reset in cycle 9 of a read miss aborts the refill
      do_reset();
      run(1'b1, 1'b0, 1'b1, 1'b0, 16, 9);
      check("abort_outputs_zero", 64'(m_any[15:10]), 64'h0);
      check("abort_no_tag_write", m_tagw, 64'h0);
      check("abort_clear_valid", m_clr, 64'h1 << 2);
      check("abort_no_ready", m_ready, 64'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/line_cache_ctr.md
# line_cache_ctr

Parametrised successor cache controller FSM for the TiniSOC memory path. It sits between the processor port and the system bus, driving the tag/data arrays and system-side transfers. It adds multi-word line refill, a built-in programmable wait-state counter and safe line invalidation during refill. Copy-back with dirty eviction is compiled in optionally.

## Interface
Parameters:
- LINE_WORDS, 4: words per cache line; power of two, 1..16.
- WAIT_CYCLES, 3: system wait cycles per word transfer; 1..15.
- IDX_W, (LINE_WORDS>1 ? log2(LINE_WORDS) : 1): width of word_index.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising clock edge.
- PStrobe  in  1  processor request; sampled only in IDLE.
- PRw  in  1  1 = read, 0 = write; held stable by processor until PReady.
- PReady  out  1  request complete, one cycle pulse.
- tag_match  in  1  addressed line tag equals request tag.
- valid  in  1  addressed line valid bit.
- dirty  in  1  addressed line dirty bit; ignored unless CACHE_WRITEBACK_EN.
- SysStrobe  out  1  one-cycle system transfer start.
- SysRW  out  1  1 = system read, 0 = system write; 0 when idle.
- word_index  out  IDX_W  word within line for refill/evict; 0 otherwise.
- evict  out  1  system address uses stored tag (eviction); 0 otherwise.
- write  out  1  cache data array write enable.
- select_CacheData  out  1  cache write data: 0 = processor, 1 = system.
- select_PData  out  1  processor read data: 0 = cache, 1 = system.
- open_SysData  out  1  drive system data bus.
- open_PData  out  1  drive processor data bus.
- clear_valid  out  1  clear addressed line valid bit.
- tag_write  out  1  write request tag, set valid, clear dirty.
- set_dirty  out  1  set addressed line dirty bit.

## Operation
- States: IDLE, LOOKUP, EVICT_REQ, EVICT_WAIT, EVICT_WORD, REFILL_REQ, REFILL_WAIT, REFILL_WORD, MERGE, WRITE_REQ, WRITE_WAIT, DONE.
- IDLE -> LOOKUP on PStrobe. Otherwise stay in IDLE.
- LOOKUP, read, hit (tag_match&&valid):
  - PReady=1, open_PData=1, select_PData=0.
  - Next state IDLE.
- LOOKUP, read, miss:
  - Without CACHE_WRITEBACK_EN -> REFILL_REQ.
  - With CACHE_WRITEBACK_EN and valid&&dirty -> EVICT_REQ; otherwise REFILL_REQ.
- LOOKUP, write, without CACHE_WRITEBACK_EN (write-through, no allocate):
  - Hit -> WRITE_REQ with write=1 for that cycle.
  - Miss -> WRITE_REQ with write=0.
- REFILL_REQ:
  - SysStrobe=1, SysRW=1.
  - Load wait counter with WAIT_CYCLES.
  - clear_valid=1 when word_index==0.
- REFILL_WAIT: decrement the counter; exit to REFILL_WORD when the counter==1.
- REFILL_WORD:
  - write=1, select_CacheData=1.
  - Last word (word_index==LINE_WORDS-1): tag_write=1, word index resets to 0. Next state is DONE for a read, MERGE for a write.
  - Otherwise: increment word index, next state REFILL_REQ.
- WRITE_REQ: SysStrobe=1, SysRW=0, open_SysData=1, load counter. WRITE_WAIT -> DONE when the counter==1.
- MERGE: write=1, select_CacheData=0, set_dirty=1. Next state DONE.
- DONE: PReady=1, open_PData=PRw, select_PData=0. Next state IDLE.
- EVICT_REQ / EVICT_WAIT / EVICT_WORD:
  - Same sequencing as refill, with SysRW=0, open_SysData=1, evict=1 and write=0.
  - After the last word -> REFILL_REQ.
- All outputs not listed for a state are 0.

## Timing
- Reset: state IDLE, counters 0, every output 0 on the next edge.
- Reset mid-transfer aborts immediately. A line interrupted mid-refill stays invalid, because clear_valid already fired and tag_write did not.
- Cycle 0 is the IDLE cycle with PStrobe=1.
- Read hit: PReady in cycle 1.
- Per word transferred: 1 REQ cycle + WAIT_CYCLES WAIT cycles + 1 WORD cycle.
- Read miss: PReady in cycle 2 + LINE_WORDS*(WAIT_CYCLES+2). Defaults give cycle 22.
- Write-through: PReady in cycle 3 + WAIT_CYCLES. Default gives cycle 6.
- PStrobe outside IDLE is ignored.
- Earliest next request: PStrobe in the cycle after PReady.
- LINE_WORDS=1: word_index constant 0; every REFILL_WORD is the last word.

## Configuration
- CACHE_WRITEBACK_EN defined (copy-back with write-allocate):
  - Write hit: LOOKUP -> MERGE -> DONE, giving PReady in cycle 3 with no system traffic.
  - Write miss: evict if valid&&dirty, then refill, then MERGE, then DONE.
  - Read miss with valid&&dirty: evict, then refill.
- CACHE_WRITEBACK_EN undefined:
  - dirty is ignored; set_dirty and evict are tied to 0.
  - EVICT_* and MERGE states are unreachable.
  - Writes are write-through, no allocate.

## Test plan
- Reset, then PStrobe=1, PRw=1, tag_match=1, valid=1 -> PReady=1 in cycle 1; SysStrobe never asserted.
- Read miss, defaults:
  - SysStrobe pulses in cycles 2, 7, 12, 17.
  - write=1 with word_index 0..3 in cycles 6, 11, 16, 21; tag_write=1 in cycle 21.
  - PReady in cycle 22.
- Write hit, no macro -> write=1 in cycle 2; SysStrobe=1, SysRW=0, open_SysData=1 in cycle 2; PReady in cycle 6.
- Reset asserted in cycle 9 of a read miss:
  - All outputs 0 from cycle 10.
  - tag_write never seen; clear_valid seen exactly once, in cycle 2.
- With CACHE_WRITEBACK_EN, write miss, valid=1, dirty=1:
  - 4 evict words with evict=1, then 4 refill words.
  - MERGE with set_dirty=1 in cycle 42; PReady in cycle 43.
- LINE_WORDS=1, WAIT_CYCLES=1, read miss -> PReady in cycle 5; word_index stays 0.
